// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, colour type and test-pattern bar colours.
package vga_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  typedef logic [11:0] rgb_t;

  localparam rgb_t BAR_WHITE   = 12'hFFF;
  localparam rgb_t BAR_YELLOW  = 12'hFF0;
  localparam rgb_t BAR_CYAN    = 12'h0FF;
  localparam rgb_t BAR_GREEN   = 12'h0F0;
  localparam rgb_t BAR_MAGENTA = 12'hF0F;
  localparam rgb_t BAR_RED     = 12'hF00;
  localparam rgb_t BAR_BLUE    = 12'h00F;
  localparam rgb_t BAR_BLACK   = 12'h000;

  function automatic rgb_t bar_color(input logic [2:0] idx);
    rgb_t c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_pix_div.sv
// System-clock divider producing a one-clk pixel strobe every CLK_DIV cycles.
module vga_pix_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic pix_tick
);

  if (CLK_DIV < 1 || CLK_DIV > 15) begin : g_bad_div
    $error("vga_pix_div: CLK_DIV must be 1..15");
  end

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

  logic [3:0] div_cnt;

  // With CLK_DIV = 1 the counter sits at 0 == DIV_LAST, so the strobe stays high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  div_cnt <= '0;
    else if (div_cnt == DIV_LAST) div_cnt <= '0;
    else                         div_cnt <= div_cnt + 4'd1;
  end

  assign pix_tick = (div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_scan_timing.sv
// VGA raster scan generator: pixel counters, sync decode and aligned colour/sync output register.
// Define VGA_TEST_PATTERN_EN to replace pixel_rgb with eight vertical colour bars.
module vga_scan_timing
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = vga_pkg::H_FP,
  parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_pkg::H_BP,
  parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = vga_pkg::V_FP,
  parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_pkg::V_BP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] pixel_rgb,
  output logic [9:0]  col,
  output logic [9:0]  row,
  output logic        video_on,
  output logic        pix_tick,
  output logic        frame_start,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b
);

  localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOT > 1023 || V_TOT > 1023) begin : g_bad_timing
    $error("vga_scan_timing: H or V total exceeds 10-bit counter range");
  end

  localparam logic [9:0] H_ACT_L  = 10'(H_ACTIVE);
  localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_ACT_L  = 10'(V_ACTIVE);
  localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] h_cnt, v_cnt;
  logic       line_end, frame_end;
  logic       hsync_n_dec, vsync_n_dec;
  rgb_t       src_rgb;
  rgb_t       rgb_q;

  vga_pix_div #(.CLK_DIV(CLK_DIV)) u_pix_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .pix_tick (pix_tick)
  );

  assign line_end  = (h_cnt == H_LAST);
  assign frame_end = (v_cnt == V_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_tick) begin
      if (line_end) begin
        h_cnt <= '0;
        v_cnt <= frame_end ? '0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  assign col         = h_cnt;
  assign row         = v_cnt;
  assign video_on    = (h_cnt < H_ACT_L) && (v_cnt < V_ACT_L);
  assign frame_start = pix_tick && line_end && frame_end;

  assign hsync_n_dec = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
  assign vsync_n_dec = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));

`ifdef VGA_TEST_PATTERN_EN
  logic [9:0] bar_idx;
  logic [2:0] bar_sel;
  logic       unused_pixel_rgb;
  assign unused_pixel_rgb = ^pixel_rgb;
  assign bar_idx = h_cnt / 10'd80;
  assign bar_sel = (bar_idx > 10'd7) ? 3'd7 : bar_idx[2:0];
  assign src_rgb = bar_color(bar_sel);
`else
  assign src_rgb = pixel_rgb;
`endif

  // Sync and colour share one register stage so they reach the pins on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      rgb_q <= '0;
    end else if (pix_tick) begin
      hsync <= hsync_n_dec;
      vsync <= vsync_n_dec;
      rgb_q <= video_on ? src_rgb : '0;
    end
  end

  assign vga_r = rgb_q[11:8];
  assign vga_g = rgb_q[7:4];
  assign vga_b = rgb_q[3:0];

endmodule

// File: tb/tb_vga_scan_timing.sv
// Self-checking bench for vga_scan_timing using a reduced raster (24x10, CLK_DIV=3).
module tb_vga_scan_timing;

  localparam int unsigned CD = 3;
  localparam int unsigned HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int unsigned VA = 6,  VF = 1, VS = 2, VB = 1;
  localparam int unsigned HT = HA + HF + HS + HB;
  localparam int unsigned VT = VA + VF + VS + VB;
  localparam int unsigned FRAME_CYC = HT * VT * CD;

  typedef struct {
    logic [9:0]  col;
    logic [9:0]  row;
    logic        von;
    logic        tick;
    logic        fs;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [11:0] pixel_rgb;
  logic [9:0]  col, row;
  logic        video_on, pix_tick, frame_start, hsync, vsync;
  logic [3:0]  vga_r, vga_g, vga_b;

  int tests;
  int fails;
  int mode;
  int unsigned n;
  bit chk_en;

  vga_scan_timing #(
    .CLK_DIV  (CD),
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pixel_rgb   (pixel_rgb),
    .col         (col),
    .row         (row),
    .video_on    (video_on),
    .pix_tick    (pix_tick),
    .frame_start (frame_start),
    .hsync       (hsync),
    .vsync       (vsync),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clock edges seen since reset release.
  always @(posedge clk) begin
    if (!rst_n) n <= 0;
    else        n <= n + 1;
  end

  function automatic logic [11:0] src_color(input int m, input int unsigned c, input int unsigned r);
    logic [31:0] cv, rv;
    cv = c;
    rv = r;
    if (m == 0)      return 12'hABC;
    else if (m == 1) return {cv[3:0], rv[3:0], 4'h5};
    else             return 12'h000;
  endfunction

  always_comb pixel_rgb = src_color(mode, col, row);

  function automatic logic [11:0] visible_color(input int m, input int unsigned c, input int unsigned r);
`ifdef VGA_TEST_PATTERN_EN
    logic [11:0] bars [8];
    int unsigned b;
    bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
    b = c / 80;
    if (b > 7) b = 7;
    return bars[b];
`else
    return src_color(m, c, r);
`endif
  endfunction

  // Outputs after nn clock edges of free run: position from tick count, registered outputs from the previous tick.
  function automatic exp_t model(input int unsigned nn, input int m);
    exp_t e;
    int unsigned t, p, q, qc, qr;
    t = nn / CD;
    p = t % (HT * VT);
    e.col  = 10'(p % HT);
    e.row  = 10'(p / HT);
    e.von  = ((p % HT) < HA) && ((p / HT) < VA);
    e.tick = ((nn % CD) == CD - 1);
    e.fs   = e.tick && (p == HT * VT - 1);
    if (t == 0) begin
      e.hs  = 1'b1;
      e.vs  = 1'b1;
      e.rgb = 12'h000;
    end else begin
      q  = (t - 1) % (HT * VT);
      qc = q % HT;
      qr = q / HT;
      e.hs  = !(qc >= HA + HF && qc < HA + HF + HS);
      e.vs  = !(qr >= VA + VF && qr < VA + VF + VS);
      e.rgb = (qc < HA && qr < VA) ? visible_color(m, qc, qr) : 12'h000;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      e = rst_n ? model(n, mode) : model(0, mode);
      tests++;
      if (col !== e.col || row !== e.row || video_on !== e.von || pix_tick !== e.tick ||
          frame_start !== e.fs || hsync !== e.hs || vsync !== e.vs || {vga_r, vga_g, vga_b} !== e.rgb) begin
        fails++;
        $display("FAIL model n=%0d: got col=%0d row=%0d von=%b tick=%b fs=%b hs=%b vs=%b rgb=%h expected col=%0d row=%0d von=%b tick=%b fs=%b hs=%b vs=%b rgb=%h",
                 n, col, row, video_on, pix_tick, frame_start, hsync, vsync, {vga_r, vga_g, vga_b},
                 e.col, e.row, e.von, e.tick, e.fs, e.hs, e.vs, e.rgb);
      end
    end
  end

  task automatic wait_pos(input string name, input int unsigned c, input int unsigned r, output bit found);
    found = 0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk);
      #1;
      if (col == 10'(c) && row == 10'(r)) found = 1;
    end
    if (!found) begin
      tests++;
      fails++;
      $display("FAIL %s: position (%0d,%0d) not reached within 3000 cycles", name, c, r);
    end
  endtask

  initial begin
    int first_tick, first_hs, hs_low, vs_low, abc_cyc, fs_cnt, fs_first, fs_second;
    bit found;
    tests = 0;
    fails = 0;
    mode  = 0;
    rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_pos", {col, row}, 20'h0);
    chk("reset_out", {hsync, vsync, vga_r, vga_g, vga_b, pix_tick, frame_start, video_on}, {2'b11, 12'h000, 3'b001});

    rst_n = 1'b1;
    first_tick = -1; first_hs = -1;
    hs_low = 0; vs_low = 0; abc_cyc = 0;
    fs_cnt = 0; fs_first = -1; fs_second = -1;
    for (int k = 0; k < 2 * int'(FRAME_CYC); k++) begin
      @(negedge clk);
      #1;
      if (pix_tick && first_tick < 0) first_tick = int'(n);
      if (!hsync && first_hs < 0) first_hs = int'(n);
      if (n <= FRAME_CYC) begin
        if (!hsync) hs_low++;
        if (!vsync) vs_low++;
        if ({vga_r, vga_g, vga_b} == 12'hABC) abc_cyc++;
      end
      if (frame_start) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = int'(n);
        else if (fs_second < 0) fs_second = int'(n);
      end
    end
    chk("first_pix_tick", first_tick, 2);
    chk("first_hsync_low", first_hs, 57);
    chk("hsync_low_cycles", hs_low, 90);
    chk("vsync_low_cycles", vs_low, 144);
    chk("active_colour_cycles", abc_cyc, 288);
    chk("frame_start_count", fs_cnt, 2);
    chk("frame_start_first", fs_first, 719);
    chk("frame_start_period", fs_second - fs_first, 720);

    // Reset in the active area: colour must blank in the same cycle.
    wait_pos("wait_active", 10, 3, found);
    if (found) begin
      chk("pre_reset_colour", {vga_r, vga_g, vga_b}, 12'hABC);
      rst_n = 1'b0;
      #1;
      chk("async_reset_colour", {vga_r, vga_g, vga_b}, 12'h000);
      chk("async_reset_pos", {col, row, frame_start}, 21'h0);
    end
    repeat (2) @(negedge clk);
    mode = 1;
    #1;
    rst_n = 1'b1;

    fs_cnt = 0;
    wait_pos("wait_c5r2", 5, 2, found);
    if (found) chk("coord_colour_lag", {hsync, vsync, vga_r, vga_g, vga_b}, {2'b11, 12'h425});
    wait_pos("wait_c16r2", 16, 2, found);
    if (found) chk("last_active_colour", {hsync, vga_r, vga_g, vga_b}, {1'b1, 12'hF25});
    wait_pos("wait_c19r2", 19, 2, found);
    if (found) chk("hsync_aligned", {hsync, vga_r, vga_g, vga_b}, {1'b0, 12'h000});
    wait_pos("wait_c0r3", 0, 3, found);
    if (found) chk("line_wrap_blank", {hsync, vga_r, vga_g, vga_b}, {1'b1, 12'h000});

    // Reset while both syncs are low: both must release high at once.
    wait_pos("wait_sync", 20, 7, found);
    if (found) begin
      chk("pre_reset_sync", {hsync, vsync}, 2'b00);
      rst_n = 1'b0;
      #1;
      chk("async_reset_sync", {hsync, vsync}, 2'b11);
    end
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      #1;
      if (frame_start) fs_cnt++;
    end
    chk("no_spurious_frame_start", fs_cnt, 0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
